// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module : reg_arb_pkg
// Brief  : Shared types and constants for the register read-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W        = 4;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DBG_RESP = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/starve_counter.sv
// ============================================================================
// Module : starve_counter
// Brief  : Saturating count of denied debug cycles; hit flags the limit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module starve_counter
  import reg_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/reg_port_arbiter.sv
// ============================================================================
// Module : reg_port_arbiter
// Brief  : Shares register-file read ports between core decode and a debug
//          reader. Debug path built only when REG_DBG_PORT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = XLEN_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Core_Req,
  input  logic [REG_IDX_W-1:0] Core_Addr_1,
  input  logic [REG_IDX_W-1:0] Core_Addr_2,
  output logic                 Core_Gnt,
  input  logic                 Dbg_Req,
  input  logic [REG_IDX_W-1:0] Dbg_Addr,
  output logic                 Dbg_Gnt,
  output logic                 Dbg_Rvalid,
  output logic [XLEN-1:0]      Dbg_Rdata,
  output logic                 REG_READ_Ctrl_1,
  output logic                 REG_READ_Ctrl_2,
  output logic [REG_IDX_W-1:0] Reg_Addr_1,
  output logic [REG_IDX_W-1:0] Reg_Addr_2,
  input  logic [XLEN-1:0]      Read_Data_1
);

  logic w_core_gnt;
  logic w_dbg_gnt;

`ifdef REG_DBG_PORT_EN
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e      state_q;
  logic            rvalid_q;
  logic [XLEN-1:0] rdata_q;
  logic            w_hit;
  logic            w_dbg_ok;

  // Debug may only win from IDLE, which spaces debug grants by one cycle.
  assign w_dbg_ok = Dbg_Req && (state_q == IDLE) && !RST;

  always_comb begin
    w_core_gnt = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (w_dbg_ok && (w_hit || !Core_Req)) begin
      w_dbg_gnt = 1'b1;
    end else if (Core_Req && !RST) begin
      w_core_gnt = 1'b1;
    end
  end

  starve_counter u_starve (
    .clk_i   (CLK),
    .rst_i   (RST),
    .inc_i   (Dbg_Req && !w_dbg_gnt),
    .clr_i   (w_dbg_gnt || !Dbg_Req),
    .limit_i (C_LIMIT),
    .hit_o   (w_hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rvalid_q <= 1'b0;
          if (w_dbg_gnt) begin
            state_q  <= DBG_RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= Read_Data_1;
          end
        end
        DBG_RESP: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Dbg_Gnt    = w_dbg_gnt;
  assign Dbg_Rvalid = rvalid_q;
  assign Dbg_Rdata  = rdata_q;
`else
  logic w_unused_dbg;

  always_comb begin
    w_dbg_gnt  = 1'b0;
    w_core_gnt = Core_Req && !RST;
  end

  assign w_unused_dbg = ^{Dbg_Req, Dbg_Addr, Read_Data_1, w_dbg_gnt};
  assign Dbg_Gnt      = 1'b0;
  assign Dbg_Rvalid   = 1'b0;
  assign Dbg_Rdata    = '0;
`endif

  always_comb begin
    REG_READ_Ctrl_1 = 1'b0;
    REG_READ_Ctrl_2 = 1'b0;
    Reg_Addr_1      = '0;
    Reg_Addr_2      = '0;
    if (w_core_gnt) begin
      REG_READ_Ctrl_1 = 1'b1;
      REG_READ_Ctrl_2 = 1'b1;
      Reg_Addr_1      = Core_Addr_1;
      Reg_Addr_2      = Core_Addr_2;
    end else if (w_dbg_gnt) begin
      REG_READ_Ctrl_1 = 1'b1;
      Reg_Addr_1      = Dbg_Addr;
    end
  end

  assign Core_Gnt = w_core_gnt;

endmodule

`default_nettype wire

// File: tb/tb_reg_port_arbiter.sv
// ============================================================================
// Module : tb_reg_port_arbiter
// Brief  : Directed, table-driven self-checking bench for reg_port_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_port_arbiter;

  logic        CLK;
  logic        RST;
  logic        Core_Req;
  logic [4:0]  Core_Addr_1;
  logic [4:0]  Core_Addr_2;
  logic        Core_Gnt;
  logic        Dbg_Req;
  logic [4:0]  Dbg_Addr;
  logic        Dbg_Gnt;
  logic        Dbg_Rvalid;
  logic [31:0] Dbg_Rdata;
  logic        REG_READ_Ctrl_1;
  logic        REG_READ_Ctrl_2;
  logic [4:0]  Reg_Addr_1;
  logic [4:0]  Reg_Addr_2;
  logic [31:0] Read_Data_1;

  int tests;
  int fails;

  typedef struct {
    logic        cr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        dr;
    logic [4:0]  da;
    logic [31:0] rd;
    logic        cg;
    logic        dg;
    logic        c1;
    logic        c2;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        rv;
    logic [31:0] rdo;
  } vec_t;

  vec_t tab[$];

  reg_port_arbiter #(
    .STARVE_LIMIT (4),
    .XLEN         (32)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .Core_Req        (Core_Req),
    .Core_Addr_1     (Core_Addr_1),
    .Core_Addr_2     (Core_Addr_2),
    .Core_Gnt        (Core_Gnt),
    .Dbg_Req         (Dbg_Req),
    .Dbg_Addr        (Dbg_Addr),
    .Dbg_Gnt         (Dbg_Gnt),
    .Dbg_Rvalid      (Dbg_Rvalid),
    .Dbg_Rdata       (Dbg_Rdata),
    .REG_READ_Ctrl_1 (REG_READ_Ctrl_1),
    .REG_READ_Ctrl_2 (REG_READ_Ctrl_2),
    .Reg_Addr_1      (Reg_Addr_1),
    .Reg_Addr_2      (Reg_Addr_2),
    .Read_Data_1     (Read_Data_1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic cr, input logic [4:0] a1, input logic [4:0] a2,
                     input logic dr, input logic [4:0] da, input logic [31:0] rd,
                     input logic cg, input logic dg, input logic c1, input logic c2,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic rv, input logic [31:0] rdo);
    vec_t v;
    v.cr = cr; v.a1 = a1; v.a2 = a2; v.dr = dr; v.da = da; v.rd = rd;
    v.cg = cg; v.dg = dg; v.c1 = c1; v.c2 = c2; v.r1 = r1; v.r2 = r2;
    v.rv = rv; v.rdo = rdo;
    tab.push_back(v);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " core_gnt"}, 32'(Core_Gnt), 32'(v.cg));
    check({tag, " dbg_gnt"}, 32'(Dbg_Gnt), 32'(v.dg));
    check({tag, " ctrl1"}, 32'(REG_READ_Ctrl_1), 32'(v.c1));
    check({tag, " ctrl2"}, 32'(REG_READ_Ctrl_2), 32'(v.c2));
    check({tag, " addr1"}, 32'(Reg_Addr_1), 32'(v.r1));
    check({tag, " addr2"}, 32'(Reg_Addr_2), 32'(v.r2));
    check({tag, " rvalid"}, 32'(Dbg_Rvalid), 32'(v.rv));
    check({tag, " rdata"}, Dbg_Rdata, v.rdo);
  endtask

  initial begin
    vec_t z;
    tests = 0;
    fails = 0;

`ifdef REG_DBG_PORT_EN
    //   cr a1  a2 dr da rd              cg dg c1 c2 r1  r2 rv rdo
    add(1, 3,  7, 0, 0, 32'h0,         1, 0, 1, 1, 3,  7, 0, 32'h0);
    add(0, 0,  0, 1, 5, 32'hDEADBEEF,  0, 1, 1, 0, 5,  0, 0, 32'h0);
    add(0, 0,  0, 0, 0, 32'h0,         0, 0, 0, 0, 0,  0, 1, 32'hDEADBEEF);
    add(0, 0,  0, 0, 0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 32'hDEADBEEF);
    add(1, 31, 0, 0, 0, 32'h0,         1, 0, 1, 1, 31, 0, 0, 32'hDEADBEEF);
    add(0, 0,  0, 1, 9, 32'h11111111,  0, 1, 1, 0, 9,  0, 0, 32'hDEADBEEF);
    add(0, 0,  0, 1, 9, 32'h22222222,  0, 0, 0, 0, 0,  0, 1, 32'h11111111);
    add(0, 0,  0, 1, 9, 32'h33333333,  0, 1, 1, 0, 9,  0, 0, 32'h11111111);
    add(0, 0,  0, 0, 0, 32'h0,         0, 0, 0, 0, 0,  0, 1, 32'h33333333);
    add(1, 1,  2, 0, 0, 32'h0,         1, 0, 1, 1, 1,  2, 0, 32'h33333333);
    for (int k = 0; k < 4; k++)
      add(1, 1, 2, 1, 4, 32'hA5A5A5A5, 1, 0, 1, 1, 1,  2, 0, 32'h33333333);
    add(1, 1,  2, 1, 4, 32'hA5A5A5A5,  0, 1, 1, 0, 4,  0, 0, 32'h33333333);
    add(1, 1,  2, 1, 4, 32'hA5A5A5A5,  1, 0, 1, 1, 1,  2, 1, 32'hA5A5A5A5);
    add(0, 0,  0, 0, 0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 32'hA5A5A5A5);
`else
    add(1, 3,  7, 0, 0, 32'h0,         1, 0, 1, 1, 3,  7, 0, 32'h0);
    add(0, 0,  0, 1, 5, 32'hDEADBEEF,  0, 0, 0, 0, 0,  0, 0, 32'h0);
    add(0, 0,  0, 1, 5, 32'hDEADBEEF,  0, 0, 0, 0, 0,  0, 0, 32'h0);
    for (int k = 0; k < 6; k++)
      add(1, 1, 2, 1, 4, 32'hA5A5A5A5, 1, 0, 1, 1, 1,  2, 0, 32'h0);
    add(0, 0,  0, 0, 0, 32'h0,         0, 0, 0, 0, 0,  0, 0, 32'h0);
`endif

    // Reset with both requesters active: nothing may be granted.
    RST = 1'b1;
    Core_Req = 1'b1; Core_Addr_1 = 5'd3; Core_Addr_2 = 5'd7;
    Dbg_Req = 1'b1; Dbg_Addr = 5'd5; Read_Data_1 = 32'hDEADBEEF;
    repeat (3) @(posedge CLK);
    #1;
    z = '{cr:0, a1:0, a2:0, dr:0, da:0, rd:0, cg:0, dg:0, c1:0, c2:0,
          r1:0, r2:0, rv:0, rdo:0};
    check_all("reset", z);

    RST = 1'b0;
    foreach (tab[i]) begin
      Core_Req    = tab[i].cr;
      Core_Addr_1 = tab[i].a1;
      Core_Addr_2 = tab[i].a2;
      Dbg_Req     = tab[i].dr;
      Dbg_Addr    = tab[i].da;
      Read_Data_1 = tab[i].rd;
      #1;
      check_all($sformatf("row%0d", i), tab[i]);
      @(posedge CLK);
      #1;
    end

`ifdef REG_DBG_PORT_EN
    // Reset landing in the response cycle must abort it.
    Core_Req = 1'b0; Dbg_Req = 1'b1; Dbg_Addr = 5'd6; Read_Data_1 = 32'h12345678;
    #1;
    check("abort grant", 32'(Dbg_Gnt), 32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1; Core_Req = 1'b1;
    #1;
    check("abort core_gnt", 32'(Core_Gnt), 32'd0);
    check("abort dbg_gnt", 32'(Dbg_Gnt), 32'd0);
    check("abort ctrl", 32'({REG_READ_Ctrl_1, REG_READ_Ctrl_2}), 32'd0);
    check("abort addr", 32'({Reg_Addr_1, Reg_Addr_2}), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0; Core_Req = 1'b0; Dbg_Req = 1'b0;
    #1;
    check("abort rvalid", 32'(Dbg_Rvalid), 32'd0);
    check("abort rdata", Dbg_Rdata, 32'h0);
    @(posedge CLK);
    #1;
    check("abort rvalid later", 32'(Dbg_Rvalid), 32'd0);
    check("abort rdata later", Dbg_Rdata, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_port_arbiter.md
REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied debug-request cycles before debug is force-granted (legal range 1..15).
REQ-002 SHALL have parameter XLEN, default 32, meaning the register data width.
REQ-003 CLK  in  1  the single clock; all state updates on the rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 Core_Req  in  1  core decode stage requests both read ports this cycle.
REQ-006 Core_Addr_1, Core_Addr_2  in  5 each  core source register indices.
REQ-007 Core_Gnt  out  1  core owns both read ports this cycle.
REQ-008 Dbg_Req  in  1  debug requester requests a single register read; held high until granted.
REQ-009 Dbg_Addr  in  5  debug register index.
REQ-010 Dbg_Gnt  out  1  debug owns read port 1 this cycle.
REQ-011 Dbg_Rvalid  out  1  Dbg_Rdata is valid, one-cycle pulse.
REQ-012 Dbg_Rdata  out  XLEN  captured debug read data.
REQ-013 REG_READ_Ctrl_1, REG_READ_Ctrl_2  out  1 each  read-enable controls to the register-file input mux; 0 selects x0.
REQ-014 Reg_Addr_1, Reg_Addr_2  out  5 each  read addresses to the register-file input mux.
REQ-015 Read_Data_1  in  XLEN  register-file port-1 combinational read data.

Function
REQ-016 The grant decision SHALL be combinational from the current state; a winner is granted in the same cycle it requests.
REQ-017 Default priority SHALL go to the core: Core_Req=1 gives Core_Gnt=1 and Dbg_Gnt=0, unless the force flag is set.
REQ-018 The force flag SHALL be set when the starvation counter equals STARVE_LIMIT; while set, Dbg_Req=1 gives Dbg_Gnt=1 and Core_Gnt=0 even if Core_Req=1.
REQ-019 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each cycle Dbg_Req=1 and Dbg_Gnt=0; it SHALL clear on Dbg_Gnt=1 or when Dbg_Req=0.
REQ-020 With Core_Req=0 and Dbg_Req=1, Dbg_Gnt SHALL be 1 regardless of the counter.
REQ-021 On Core_Gnt: Reg_Addr_1=Core_Addr_1, Reg_Addr_2=Core_Addr_2, both REG_READ_Ctrl=1.
REQ-022 On Dbg_Gnt: Reg_Addr_1=Dbg_Addr, REG_READ_Ctrl_1=1, REG_READ_Ctrl_2=0, Reg_Addr_2=0.
REQ-023 With no grant, both REG_READ_Ctrl SHALL be 0 and both Reg_Addr SHALL be 0.
REQ-024 The FSM SHALL have states IDLE and DBG_RESP: IDLE->DBG_RESP on Dbg_Gnt; DBG_RESP->IDLE unconditionally after one cycle.
REQ-025 On Dbg_Gnt, Read_Data_1 SHALL be registered into Dbg_Rdata; Dbg_Rvalid=1 exactly in DBG_RESP, giving one cycle of latency.
REQ-026 In DBG_RESP, Dbg_Gnt SHALL be 0, so back-to-back debug grants are separated by at least one cycle; core grants remain allowed.
REQ-027 Dbg_Rdata SHALL hold its value until the next debug grant.
REQ-028 Core_Gnt and Dbg_Gnt SHALL never both be 1 in the same cycle.

Reset
REQ-029 With RST=1 at a clock edge: state=IDLE, counter=0, Dbg_Rdata=0, Dbg_Rvalid=0.
REQ-030 While RST=1, Core_Gnt, Dbg_Gnt and both REG_READ_Ctrl SHALL be 0, and both Reg_Addr SHALL be 0.
REQ-031 Reset asserted in DBG_RESP SHALL abort the response; no Dbg_Rvalid pulse follows.

Configuration
REQ-032 With macro REG_DBG_PORT_EN defined, the debug path SHALL be present as specified.
REQ-033 With REG_DBG_PORT_EN undefined, Dbg_Gnt, Dbg_Rvalid and Dbg_Rdata SHALL be tied to 0, Dbg_Req SHALL be ignored, and the FSM and counter SHALL be absent; the port list SHALL remain unchanged.

Structure
REQ-034 A shared package reg_arb_pkg SHALL hold the state enum (IDLE, DBG_RESP), the register-index width constant (5) and the XLEN default.
REQ-035 The starvation counter SHALL be one sub-module, starve_counter (inc, clr, limit in; hit out).

Verification
REQ-036 Core_Req=1, Core_Addr_1=3, Core_Addr_2=7, Dbg_Req=0 -> Core_Gnt=1, Reg_Addr=3/7, both REG_READ_Ctrl=1.
REQ-037 Core_Req=0, Dbg_Req=1, Dbg_Addr=5, Read_Data_1=0xDEADBEEF -> Dbg_Gnt same cycle; next cycle Dbg_Rvalid=1, Dbg_Rdata=0xDEADBEEF.
REQ-038 Core_Req and Dbg_Req held at 1 with STARVE_LIMIT=4 -> core wins 4 cycles, debug wins cycle 5, core wins cycle 6, counter=0 after the grant.
REQ-039 Dbg_Req held at 1, Core_Req=0 -> Dbg_Gnt pattern 1,0,1,0 with a Dbg_Rvalid pulse following each grant.
REQ-040 RST=1 asserted in the DBG_RESP cycle -> Dbg_Rvalid=0, all grants 0, Dbg_Rdata=0.
REQ-041 Build with REG_DBG_PORT_EN undefined, Dbg_Req=1, Core_Req=0 -> Dbg_Gnt=0, REG_READ_Ctrl=0/0, Dbg_Rvalid never asserts.
